// File: rtl/phased_clock_bank.sv
// phased_clock_bank: CHANNELS square waves sharing one master counter, each with its own
// phase offset. Double-buffered updates land on a period boundary. Define PHASED_CLOCK_DUTY_EN for per-channel duty.
module phased_clock_bank #(
  parameter int CHANNELS       = 8,
  parameter int CNT_WIDTH      = 11,
  parameter int PERIOD_DEFAULT = 1250,
  localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [CW-1:0]        wr_chan,
  input  logic [CNT_WIDTH-1:0] wr_phase,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic                 commit,
  input  logic [CHANNELS-1:0]  chan_en,
  input  logic                 oe,
`ifdef PHASED_CLOCK_DUTY_EN
  input  logic [CNT_WIDTH-1:0] wr_duty,
`endif
  output logic [CHANNELS-1:0]  out,
  output logic                 pending,
  output logic                 sync,
  output logic [CHANNELS-1:0]  phase_err
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t P_RST    = cnt_t'(PERIOD_DEFAULT);
  localparam cnt_t DUTY_RST = cnt_t'(PERIOD_DEFAULT >> 1);

  cnt_t                mcnt_q, mcnt_d;
  cnt_t                period_q, period_d;
  cnt_t                period_sh_q, period_sh_d;
  cnt_t                phase_q    [CHANNELS];
  cnt_t                phase_d    [CHANNELS];
  cnt_t                phase_sh_q [CHANNELS];
  cnt_t                phase_sh_d [CHANNELS];
`ifdef PHASED_CLOCK_DUTY_EN
  cnt_t                duty_q     [CHANNELS];
  cnt_t                duty_d     [CHANNELS];
  cnt_t                duty_sh_q  [CHANNELS];
  cnt_t                duty_sh_d  [CHANNELS];
`endif
  logic                pending_q, pending_d;
  logic                sync_q, sync_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] err_c;

  cnt_t p_eff;
  logic boundary;
  logic apply;

  // Periods below 2 would leave no room for a high and a low half.
  assign p_eff    = (period_q < cnt_t'(2)) ? cnt_t'(2) : period_q;
  assign boundary = (mcnt_q == p_eff - cnt_t'(1));
  // A commit landing on the boundary itself applies immediately, using period_in directly.
  assign apply    = boundary && (pending_q || commit);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    mcnt_d      = boundary ? '0 : mcnt_q + cnt_t'(1);
    period_d    = period_q;
    period_sh_d = commit ? period_in : period_sh_q;
    pending_d   = pending_q;
    sync_d      = boundary;
    phase_d     = phase_q;
    phase_sh_d  = phase_sh_q;
`ifdef PHASED_CLOCK_DUTY_EN
    duty_d      = duty_q;
    duty_sh_d   = duty_sh_q;
`endif

    // Active values load from the shadow as it stood before this cycle's write.
    if (apply) begin
      period_d  = commit ? period_in : period_sh_q;
      phase_d   = phase_sh_q;
`ifdef PHASED_CLOCK_DUTY_EN
      duty_d    = duty_sh_q;
`endif
      pending_d = 1'b0;
    end else if (commit) begin
      pending_d = 1'b1;
    end

    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en && (wr_chan == CW'(i))) begin
        phase_sh_d[i] = wr_phase;
`ifdef PHASED_CLOCK_DUTY_EN
        duty_sh_d[i]  = wr_duty;
`endif
      end
    end
  end

  always_comb begin
    logic [CNT_WIDTH:0] pos;
    logic [CNT_WIDTH:0] thresh;
    pos    = '0;
    thresh = '0;
    err_c  = '0;
    out_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pos = {1'b0, mcnt_q} + {1'b0, phase_q[i]};
      if (pos >= {1'b0, p_eff}) pos = pos - {1'b0, p_eff};
`ifdef PHASED_CLOCK_DUTY_EN
      thresh = {1'b0, duty_q[i]};
`else
      thresh = {1'b0, p_eff >> 1};
`endif
      err_c[i] = (phase_q[i] >= p_eff);
      out_d[i] = (pos < thresh) & chan_en[i] & oe & ~err_c[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcnt_q      <= '0;
      period_q    <= P_RST;
      period_sh_q <= P_RST;
      pending_q   <= 1'b0;
      sync_q      <= 1'b0;
      out_q       <= '0;
      // NOTE: the phase/duty arrays are plain flops whose reset values matter, so they are reset too.
      for (int i = 0; i < CHANNELS; i++) begin
        phase_q[i]    <= '0;
        phase_sh_q[i] <= '0;
`ifdef PHASED_CLOCK_DUTY_EN
        duty_q[i]     <= DUTY_RST;
        duty_sh_q[i]  <= DUTY_RST;
`endif
      end
    end else begin
      mcnt_q      <= mcnt_d;
      period_q    <= period_d;
      period_sh_q <= period_sh_d;
      pending_q   <= pending_d;
      sync_q      <= sync_d;
      out_q       <= out_d;
      phase_q     <= phase_d;
      phase_sh_q  <= phase_sh_d;
`ifdef PHASED_CLOCK_DUTY_EN
      duty_q      <= duty_d;
      duty_sh_q   <= duty_sh_d;
`endif
    end
  end

  assign out       = out_q;
  assign pending   = pending_q;
  assign sync      = sync_q;
  assign phase_err = err_c;

endmodule

// File: tb/tb_phased_clock_bank.sv
// Self-checking bench for phased_clock_bank: a formula-filled vector table for the first
// reconfiguration, then hand-written corner sequences scored against a small behavioural model.
module tb_phased_clock_bank;

  localparam int CH  = 6;
  localparam int W   = 8;
  localparam int PD  = 12;
  localparam int CHW = 3;
`ifdef PHASED_CLOCK_DUTY_EN
  localparam int TAB_T = 6;
`else
  localparam int TAB_T = 5;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [CHW-1:0] wr_chan;
  logic [W-1:0]   wr_phase;
  logic [W-1:0]   period_in;
  logic           commit;
  logic [CH-1:0]  chan_en;
  logic           oe;
`ifdef PHASED_CLOCK_DUTY_EN
  logic [W-1:0]   wr_duty;
`endif
  logic [CH-1:0]  out;
  logic           pending;
  logic           sync;
  logic [CH-1:0]  phase_err;

  always #5 clk = ~clk;

  phased_clock_bank #(
    .CHANNELS      (CH),
    .CNT_WIDTH     (W),
    .PERIOD_DEFAULT(PD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_chan  (wr_chan),
    .wr_phase (wr_phase),
    .period_in(period_in),
    .commit   (commit),
    .chan_en  (chan_en),
    .oe       (oe),
`ifdef PHASED_CLOCK_DUTY_EN
    .wr_duty  (wr_duty),
`endif
    .out      (out),
    .pending  (pending),
    .sync     (sync),
    .phase_err(phase_err)
  );

  typedef struct {
    logic [CH-1:0] out;
    logic          sync;
    logic          pending;
    logic [CH-1:0] err;
  } exp_t;

  typedef struct {
    logic           wr_en;
    logic [CHW-1:0] wr_chan;
    logic [W-1:0]   wr_phase;
    logic [W-1:0]   period_in;
    logic           commit;
    exp_t           exp;
  } vec_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Behavioural model state (counter value before the coming edge, active and shadow settings).
  int   m_mc, m_p, m_shp;
  int   m_ph[CH], m_sh_ph[CH], m_t[CH], m_sh_t[CH];
  logic m_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic lvl(input int m, input int ph, input int p, input int t);
    return ((m + ph) % p) < t;
  endfunction

  function automatic int peff();
    return (m_p < 2) ? 2 : m_p;
  endfunction

  function automatic logic [CH-1:0] m_out();
    logic [CH-1:0] r;
    int thr;
    r = '0;
    for (int i = 0; i < CH; i++) begin
`ifdef PHASED_CLOCK_DUTY_EN
      thr = m_t[i];
`else
      thr = peff() / 2;
`endif
      if (m_ph[i] < peff() && chan_en[i] && oe) r[i] = lvl(m_mc, m_ph[i], peff(), thr);
    end
    return r;
  endfunction

  function automatic logic [CH-1:0] m_err();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (m_ph[i] >= peff());
    return r;
  endfunction

  task automatic m_reset();
    m_mc = 0; m_p = PD; m_shp = PD; m_pend = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_ph[i] = 0; m_sh_ph[i] = 0; m_t[i] = PD / 2; m_sh_t[i] = PD / 2;
    end
  endtask

  // Predict the outputs of the coming edge, queue them, clock, then compare what the DUT shows.
  task automatic step(input string tag, input logic use_tab, input exp_t tab);
    exp_t e;
    logic bnd;
    if (rst) begin
      m_reset();
      e.out = '0; e.sync = 1'b0; e.pending = 1'b0; e.err = '0;
    end else begin
      bnd    = (m_mc == peff() - 1);
      e.out  = m_out();
      e.sync = bnd;
      if (bnd && (m_pend || commit)) begin
        m_p    = commit ? int'(period_in) : m_shp;
        m_ph   = m_sh_ph;
        m_t    = m_sh_t;
        m_mc   = 0;
        m_pend = 1'b0;
      end else begin
        m_mc = bnd ? 0 : m_mc + 1;
        if (commit) m_pend = 1'b1;
      end
      if (commit) m_shp = int'(period_in);
      if (wr_en && int'(wr_chan) < CH) begin
        m_sh_ph[wr_chan] = int'(wr_phase);
`ifdef PHASED_CLOCK_DUTY_EN
        m_sh_t[wr_chan]  = int'(wr_duty);
`endif
      end
      e.pending = m_pend;
      e.err     = m_err();
    end
    sb_q.push_back(use_tab ? tab : e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " out"}, 64'(out), 64'(e.out));
      check({tag, " sync"}, 64'(sync), 64'(e.sync));
      check({tag, " pending"}, 64'(pending), 64'(e.pending));
      check({tag, " phase_err"}, 64'(phase_err), 64'(e.err));
    end
  endtask

  task automatic idle(input string tag, input int n);
    exp_t z;
    z = '{default: '0};
    for (int i = 0; i < n; i++) step(tag, 1'b0, z);
  endtask

  task automatic run_to(input string tag, input int target);
    exp_t z;
    z = '{default: '0};
    for (int i = 0; i < 64 && m_mc != target; i++) step(tag, 1'b0, z);
  endtask

  vec_t tab[32];
  int   tab_ph[CH] = '{0, 3, 7, 12, 0, 0};
  exp_t z;
  int   m;

  initial begin
    z = '{default: '0};
    // Reconfiguration after reset: phases 0/3/7/12, commit P=10, then two full periods.
    for (int n = 1; n <= 32; n++) begin
      tab[n-1].wr_en     = (n <= 3);
      tab[n-1].wr_chan   = CHW'(n);
      tab[n-1].wr_phase  = (n <= 3) ? W'(tab_ph[n]) : '0;
      tab[n-1].period_in = 8'd10;
      tab[n-1].commit    = (n == 4);
      if (n <= 12) begin
        tab[n-1].exp.out     = (n - 1 < 6) ? '1 : '0;
        tab[n-1].exp.sync    = (n == 12);
        tab[n-1].exp.pending = (n >= 4 && n <= 11);
        tab[n-1].exp.err     = (n == 12) ? 6'b001000 : 6'b000000;
      end else begin
        m = (n - 13) % 10;
        for (int i = 0; i < CH; i++)
          tab[n-1].exp.out[i] = (i != 3) && lvl(m, tab_ph[i], 10, TAB_T);
        tab[n-1].exp.sync    = (m == 9);
        tab[n-1].exp.pending = 1'b0;
        tab[n-1].exp.err     = 6'b001000;
      end
    end

    rst = 1'b1; wr_en = 1'b0; wr_chan = '0; wr_phase = '0; period_in = 8'd10;
    commit = 1'b0; chan_en = '1; oe = 1'b1;
`ifdef PHASED_CLOCK_DUTY_EN
    wr_duty = 8'd6;
`endif
    m_reset();
    idle("reset", 2);
    rst = 1'b0;

    for (int n = 0; n < 32; n++) begin
      wr_en     = tab[n].wr_en;
      wr_chan   = tab[n].wr_chan;
      wr_phase  = tab[n].wr_phase;
      period_in = tab[n].period_in;
      commit    = tab[n].commit;
      step($sformatf("vec%0d", n), 1'b1, tab[n].exp);
    end
    wr_en = 1'b0; commit = 1'b0;

    // Shadow writes mid-period, commit at mcnt=4; an out-of-range channel write is dropped.
    run_to("pre_wr", 1);
    wr_en = 1'b1; wr_chan = 3'd7; wr_phase = 8'd4; step("wr_oor", 1'b0, z);
    wr_chan = 3'd0; wr_phase = 8'd5; step("wr_ch0", 1'b0, z);
    wr_chan = 3'd3; wr_phase = 8'd2; step("wr_ch3", 1'b0, z);
    wr_en = 1'b0; commit = 1'b1; period_in = 8'd10; step("commit4", 1'b0, z);
    commit = 1'b0;
    idle("pend_wait", 5);
    idle("new_phase", 10);

    // Commit on the boundary itself, with a same-cycle write that must wait.
    run_to("to_bnd", 9);
    commit = 1'b1; period_in = 8'd8; wr_en = 1'b1; wr_chan = 3'd1; wr_phase = 8'd6;
    step("commit_bnd", 1'b0, z);
    commit = 1'b0; wr_en = 1'b0;
    idle("p8", 16);

    // Re-commit while pending: the later period wins.
    run_to("to2", 2);
    commit = 1'b1; period_in = 8'd12; step("recommit_a", 1'b0, z);
    commit = 1'b0;
    run_to("to4", 4);
    commit = 1'b1; period_in = 8'd6; step("recommit_b", 1'b0, z);
    commit = 1'b0;
    run_to("to_wrap", 0);
    idle("p6", 12);

    // Global and per-channel enables gate the outputs without disturbing alignment.
    run_to("to1", 1);
    oe = 1'b0; idle("oe_off", 3);
    oe = 1'b1; chan_en[0] = 1'b0; chan_en[4] = 1'b0; idle("ch_off", 3);
    chan_en = '1; idle("reenable", 6);

    // Period 1 behaves as period 2.
    commit = 1'b1; period_in = 8'd1; step("commit_p1", 1'b0, z);
    commit = 1'b0;
    run_to("to_wrap1", 0);
    idle("p2", 6);

`ifdef PHASED_CLOCK_DUTY_EN
    wr_en = 1'b1; wr_phase = 8'd0;
    wr_chan = 3'd0; wr_duty = 8'd0;  step("duty0", 1'b0, z);
    wr_chan = 3'd1; wr_duty = 8'd3;  step("duty3", 1'b0, z);
    wr_chan = 3'd2; wr_duty = 8'd10; step("duty10", 1'b0, z);
    wr_chan = 3'd3; wr_duty = 8'd5;  step("duty5", 1'b0, z);
    wr_en = 1'b0; wr_duty = 8'd6;
    commit = 1'b1; period_in = 8'd10; step("commit_duty", 1'b0, z);
    commit = 1'b0;
    run_to("to_wrap_d", 0);
    idle("duty_run", 21);
`endif

    // Reset while a commit is pending discards it and restores the default period.
    run_to("to3", 3);
    commit = 1'b1; period_in = 8'd9; step("commit_lost", 1'b0, z);
    commit = 1'b0;
    rst = 1'b1; step("mid_reset", 1'b0, z);
    rst = 1'b0;
    idle("after_reset", 26);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/phased_clock_bank.md
PHASED_CLOCK_BANK -- requirements
Module: phased_clock_bank

Interface
REQ-001 Parameter CHANNELS, default 8: number of phased outputs, 1..64.
REQ-002 Parameter CNT_WIDTH, default 11: width of counter, period and phase values.
REQ-003 Parameter PERIOD_DEFAULT, default 1250: active period after reset (50 MHz clk -> 40 kHz).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  write strobe for the shadow phase register selected by wr_chan.
REQ-007 wr_chan  in  $clog2(CHANNELS) (min 1)  channel index for wr_en; values >= CHANNELS ignored.
REQ-008 wr_phase  in  CNT_WIDTH  phase offset, in ticks, written to the shadow register.
REQ-009 period_in  in  CNT_WIDTH  requested period, in ticks, captured to shadow on commit.
REQ-010 commit  in  1  pulse: request shadow-to-active transfer at the next period boundary.
REQ-011 chan_en  in  CHANNELS  per-channel output enable.
REQ-012 oe  in  1  global output enable.
REQ-013 out  out  CHANNELS  registered square-wave outputs.
REQ-014 pending  out  1  high from commit until the transfer completes.
REQ-015 sync  out  1  one-cycle pulse on every period boundary.
REQ-016 phase_err  out  CHANNELS  active phase >= active period for that channel.

Function
REQ-017 Master counter mcnt SHALL count 0..P-1 (P = active period) and wrap to 0; boundary cycle = mcnt==P-1.
REQ-018 Active P below 2 SHALL be treated as 2.
REQ-019 Per channel i: pos = mcnt + phase_i, minus P if >= P; level_i = (pos < T_i), T_i = P>>1 (floor).
REQ-020 out[i] SHALL register level_i & chan_en[i] & oe & ~phase_err[i]; one-cycle latency from mcnt.
REQ-021 phase_err[i] SHALL be combinational on active values; out[i] held low while set.
REQ-022 Write with wr_en SHALL update only the shadow; active outputs unaffected until commit applies.
REQ-023 commit SHALL capture period_in to shadow period and set pending on the next edge.
REQ-024 On a boundary cycle with pending set, all active phases and active P SHALL load from shadow, mcnt wraps to 0, pending clears; all channels switch on the same edge.
REQ-025 commit asserted in a boundary cycle with pending low SHALL apply at that same boundary (pending never observed high).
REQ-026 wr_en in the same cycle as an applying boundary SHALL NOT be included; it waits for a later commit.
REQ-027 commit while pending is high SHALL re-capture period_in; transfer still at the next boundary.
REQ-028 sync SHALL be registered: high the cycle after a boundary cycle, i.e. while mcnt==0.
REQ-029 Shrinking P below current mcnt cannot occur, since P changes only at wrap.

Reset
REQ-030 rst SHALL set mcnt=0, all shadow and active phases=0, shadow and active P=PERIOD_DEFAULT.
REQ-031 rst SHALL drive out=0, pending=0, sync=0 on the next edge.
REQ-032 rst mid-period or with pending high SHALL discard pending writes and commits.

Configuration
REQ-033 Macro PHASED_CLOCK_DUTY_EN, when defined, SHALL add input wr_duty (CNT_WIDTH) with a per-channel shadow and active duty register.
REQ-034 With the macro, wr_duty SHALL be written with wr_en alongside wr_phase, transfer with phase on commit, and reset to PERIOD_DEFAULT>>1.
REQ-035 With the macro, T_i SHALL equal active duty_i: 0 means always low; >= P means always high.
REQ-036 Without the macro, wr_duty and duty registers SHALL be absent and T_i = P>>1.

Verification
REQ-037 Reset with P=10, phases 0 and 3, commit, all enables high -> ch0 high at mcnt 0..4; ch1 high at mcnt 7,8,9,0,1 (out delayed one cycle).
REQ-038 Write phase 5 to ch0 mid-period, then commit at mcnt=4 -> ch0 unchanged through mcnt=9; pending high 5 cycles; new phase from mcnt=0.
REQ-039 Commit exactly at mcnt=P-1 -> applied at that boundary; pending stays 0; sync pulses at mcnt=0.
REQ-040 Phase 12 with P=10 -> phase_err[i]=1, out[i]=0; rewrite phase 2 and commit -> recovers at next boundary.
REQ-041 oe=0 or chan_en[i]=0 -> out low next cycle; counter and phases keep running, so re-enable restores the same alignment.
REQ-042 With PHASED_CLOCK_DUTY_EN defined, P=10: duty 0 -> constant low; duty 3 -> 3 high cycles per period; duty 10 -> constant high.
